disp_num_seq: RTL and testbench

Sequential, parametrised successor to the combinational DOUT display decoder. Accepts a WIDTH-bit two's-complement value on a load strobe and converts it into DIGITS seven-segment patterns. In decimal mode it runs a serial double-dabble conversion, blanks leading zeros, places a floating minus sign and flags overflow. In binary mode it shows two bits per digit. Sits between the datapath DOUT register and the board's seven-segment pins.

---
 rtl/disp_num_seq_pkg.sv | 52 +++++
 rtl/disp_num_seq_bcd_digit_to_sseg.sv | 11 +
 rtl/disp_num_seq.sv | 190 +++++++++++++++++++
 tb/tb_disp_num_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_num_seq_pkg.sv
// Shared constants, state encoding and glyph helpers for the sequential display decoder.
package disp_num_seq_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FMT  = 2'd2
    } state_t;

    // Nibbles needed to hold 2^width in BCD: ceil(width*log10(2)) + 1
    function automatic int bcd_nibbles(input int width);
        return (width * 30103 + 99999) / 100000 + 1;
    endfunction

    // Decimal glyphs 0-9; any non-BCD code renders blank
    function automatic logic [6:0] dec_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Two bits per digit: d always lit, high bit lights f/e, low bit lights b/c
    function automatic logic [6:0] bin_glyph(input logic [1:0] b);
        logic [6:0] seg;
        seg = 7'b1110111;
        if (b[1]) begin
            seg[5] = 1'b0;
            seg[4] = 1'b0;
        end
        if (b[0]) begin
            seg[2] = 1'b0;
            seg[1] = 1'b0;
        end
        return seg;
    endfunction

endpackage

// File: rtl/disp_num_seq_bcd_digit_to_sseg.sv
// Single BCD digit to active-low seven-segment pattern.
module bcd_digit_to_sseg
    import disp_num_seq_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = dec_glyph(bcd_i);

endmodule

// File: rtl/disp_num_seq.sv
// Sequential display decoder: serial double-dabble for decimal, direct 2-bit glyphs for binary.
module disp_num_seq
    import disp_num_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    x,
    input  logic                mode,
    input  logic                load,
    input  logic                enable,
    output logic [7*DIGITS-1:0] disp,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    localparam int NB = bcd_nibbles(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 2 * DIGITS;
    localparam logic [7*DIGITS-1:0] DISP_BLANK = {DIGITS{SEG_BLANK}};

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic [4*NB-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                mode_q, mode_d;
    logic [7*DIGITS-1:0] disp_q, disp_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [WIDTH-1:0]    abs_x;
    logic [4*NB-1:0]     bcd_adj;
    logic [4*NB-1:0]     bcd_step;
    logic [WIDTH-1:0]    mag_step;
    logic [7*DIGITS-1:0] dec_glyphs;
    logic [7*DIGITS-1:0] dec_disp;
    logic [7*DIGITS-1:0] bin_disp;
    logic [BW-1:0]       bin_bits;
    logic                dec_ovf;
    int                  lead;

    // Most negative input wraps to 2^(WIDTH-1), which still fits as unsigned
    assign abs_x = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;

    // One double-dabble step: add-3 correction, then shift the magnitude MSB into the BCD register
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_step = {bcd_adj[4*NB-2:0], mag_q[WIDTH-1]};
        mag_step = {mag_q[WIDTH-2:0], 1'b0};
    end

    // Binary view: bits beyond the input width read as zero
    for (genvar i = 0; i < BW; i++) begin : g_bin_bit
        if (i < WIDTH) begin : g_src
            assign bin_bits[i] = mag_q[i];
        end else begin : g_zero
            assign bin_bits[i] = 1'b0;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] nib;
        if (k < NB) begin : g_nib
            assign nib = bcd_q[4*k +: 4];
        end else begin : g_pad
            assign nib = 4'd0;
        end

        bcd_digit_to_sseg u_sseg (
            .bcd_i (nib),
            .seg_o (dec_glyphs[7*k +: 7])
        );

        assign bin_disp[7*k +: 7] = bin_glyph(bin_bits[2*k +: 2]);
    end

    // Locate the leading nonzero nibble and lay out glyphs, floating minus and overflow marker
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        lead     = 0;
        dec_disp = DISP_BLANK;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                lead = i;
            end
        end
        dec_ovf = (lead + 1 + (neg_q ? 1 : 0)) > DIGITS;
        if (dec_ovf) begin
            dec_disp[6:0] = SEG_E;
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                if (k <= lead) begin
                    dec_disp[7*k +: 7] = dec_glyphs[7*k +: 7];
                end else if (neg_q && (k == lead + 1)) begin
                    dec_disp[7*k +: 7] = SEG_MINUS;
                end
            end
        end
    end

    // Next-state logic: capture on load, WIDTH conversion steps, one formatting cycle
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        mode_d  = mode_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    mode_d = mode;
                    if (mode) begin
                        mag_d   = x;
                        neg_d   = 1'b0;
                        state_d = ST_FMT;
                    end else begin
                        mag_d   = abs_x;
                        neg_d   = x[WIDTH-1];
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                bcd_d = bcd_step;
                mag_d = mag_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FMT;
                end
            end
            ST_FMT: begin
                disp_d  = mode_q ? bin_disp : dec_disp;
                ovf_d   = mode_q ? 1'b0 : dec_ovf;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset that discards any conversion in flight
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            mode_q  <= 1'b0;
            disp_q  <= DISP_BLANK;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            mode_q  <= mode_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign disp = enable ? disp_q : DISP_BLANK;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_disp_num_seq.sv
// Scoreboard bench: stimulus pushes hand-computed results, monitors pop and compare on done.
module tb_disp_num_seq;

    typedef struct {
        logic [27:0] disp;
        logic        ovf;
        int          cyc;
    } exp_t;

    localparam logic [27:0] ALL_BLANK = 28'hFFFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;

    logic [7:0]  x8 = '0;
    logic        mode8 = 1'b0;
    logic        load8 = 1'b0;
    logic [27:0] disp8;
    logic        busy8, done8, ovf8;

    logic [11:0] x12 = '0;
    logic        mode12 = 1'b0;
    logic        load12 = 1'b0;
    logic [27:0] disp12;
    logic        busy12, done12, ovf12;

    exp_t q8[$];
    exp_t q12[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    disp_num_seq #(.WIDTH(8), .DIGITS(4)) u_dut8 (
        .clk    (clk),
        .reset  (reset),
        .x      (x8),
        .mode   (mode8),
        .load   (load8),
        .enable (enable),
        .disp   (disp8),
        .busy   (busy8),
        .done   (done8),
        .ovf    (ovf8)
    );

    disp_num_seq #(.WIDTH(12), .DIGITS(4)) u_dut12 (
        .clk    (clk),
        .reset  (reset),
        .x      (x12),
        .mode   (mode12),
        .load   (load12),
        .enable (enable),
        .disp   (disp12),
        .busy   (busy12),
        .done   (done12),
        .ovf    (ovf12)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // 8-bit monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done8) begin
            if (q8.size() == 0) begin
                check("dut8 pending results", q8.size(), 1);
            end else begin
                e = q8.pop_front();
                check("dut8 done cycle", cyc, e.cyc);
                check("dut8 disp", disp8, enable ? e.disp : ALL_BLANK);
                check("dut8 ovf", ovf8, e.ovf);
            end
        end
    end

    // 12-bit monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done12) begin
            if (q12.size() == 0) begin
                check("dut12 pending results", q12.size(), 1);
            end else begin
                e = q12.pop_front();
                check("dut12 done cycle", cyc, e.cyc);
                check("dut12 disp", disp12, enable ? e.disp : ALL_BLANK);
                check("dut12 ovf", ovf12, e.ovf);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the load edge
    task automatic go8(input logic [7:0] v, input logic m, input logic [27:0] ed, input logic eo);
        exp_t e;
        x8 = v; mode8 = m; load8 = 1'b1;
        e.disp = ed; e.ovf = eo; e.cyc = cyc + (m ? 2 : 10);
        q8.push_back(e);
        @(negedge clk);
        load8 = 1'b0;
    endtask

    task automatic go12(input logic [11:0] v, input logic [27:0] ed, input logic eo);
        exp_t e;
        x12 = v; mode12 = 1'b0; load12 = 1'b1;
        e.disp = ed; e.ovf = eo; e.cyc = cyc + 14;
        q12.push_back(e);
        @(negedge clk);
        load12 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("dut8 result arrived", q8.size(), 0);
        q8.delete();
    endtask

    task automatic drain12();
        int n = 0;
        while (q12.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("dut12 result arrived", q12.size(), 0);
        q12.delete();
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset disp8", disp8, ALL_BLANK);
        check("reset busy8", busy8, 0);
        check("reset done8", done8, 0);
        check("reset ovf8", ovf8, 0);
        check("reset disp12", disp12, ALL_BLANK);

        // -128: busy for WIDTH+1 cycles, "-128"
        go8(8'h80, 1'b0, {7'h3F, 7'h79, 7'h24, 7'h00}, 1'b0);
        n = 0;
        while (busy8 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy8 decimal window", n, 9);
        drain8();

        go8(8'd7,   1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0); drain8();
        go8(8'd0,   1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0); drain8();
        go8(8'd127, 1'b0, {7'h7F, 7'h79, 7'h24, 7'h78}, 1'b0); drain8();

        // Binary 10_11_01_00
        go8(8'b10110100, 1'b1, {7'h47, 7'h41, 7'h71, 7'h77}, 1'b0);
        n = 0;
        while (busy8 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy8 binary window", n, 1);
        drain8();
        go8(8'hFF, 1'b1, {7'h41, 7'h41, 7'h41, 7'h41}, 1'b0); drain8();

        // Back-to-back: second load issued in the done cycle
        go8(8'd5, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b0);
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("dut8 first of pair done", done8, 1);
        go8(8'hF7, 1'b0, {7'h7F, 7'h7F, 7'h3F, 7'h10}, 1'b0);
        drain8();

        // Load during CONV is ignored
        go8(8'd42, 1'b0, {7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0);
        repeat (3) @(negedge clk);
        x8 = 8'd99; load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        drain8();
        repeat (12) @(negedge clk);

        // enable=0 blanks output but done keeps its schedule
        go8(8'd100, 1'b0, {7'h7F, 7'h79, 7'h40, 7'h40}, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        drain8();
        check("enable0 disp8", disp8, ALL_BLANK);
        enable = 1'b1;
        #1;
        check("enable1 disp8", disp8, {7'h7F, 7'h79, 7'h40, 7'h40});

        // 12-bit decimal boundaries
        @(negedge clk);
        go12(12'h800, {7'h7F, 7'h7F, 7'h7F, 7'h06}, 1'b1); drain12();
        repeat (3) @(negedge clk);
        check("ovf12 held", ovf12, 1);
        check("disp12 held", disp12, {7'h7F, 7'h7F, 7'h7F, 7'h06});
        go12(12'd2047, {7'h24, 7'h40, 7'h19, 7'h78}, 1'b0); drain12();
        go12(12'd1000, {7'h79, 7'h40, 7'h40, 7'h40}, 1'b0); drain12();
        go12(-12'sd1000, {7'h7F, 7'h7F, 7'h7F, 7'h06}, 1'b1); drain12();

        // Reset in the middle of a conversion discards it
        x12 = 12'd5; load12 = 1'b1;
        @(negedge clk);
        load12 = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset disp12", disp12, ALL_BLANK);
        check("midreset busy12", busy12, 0);
        check("midreset ovf12", ovf12, 0);
        check("midreset done12", done12, 0);
        check("midreset disp8", disp8, ALL_BLANK);
        repeat (16) @(negedge clk);

        go12(-12'sd999, {7'h3F, 7'h10, 7'h10, 7'h10}, 1'b0); drain12();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
